uart_rx: RTL
============

# uart_rx

Serial-to-parallel UART receiver: 8N1 frames, LSB first, idle-high line. Recovers bytes sent by the team's `uart_tx` over a single wire. It presents each byte as a parallel word with a one-cycle valid strobe to the downstream command/data logic. A separate one-cycle strobe flags a bad stop bit.

## Interface
- `baud_rate`, 24'd4000000, line bit rate in bits/s.
- `clock_freq`, 28'd50000000, `uart_clock` frequency in Hz.
- Derived constants (localparams):
  - BIT_CYCLES = clock_freq/baud_rate + 1, the cycles per bit; this matches the transmitter's bit hold time. Default is 13.
  - HALF = BIT_CYCLES/2, integer division. Default is 6.
  - BIT_CYCLES ≥ 4 is required.

- `uart_clock`  input  1  sole clock, rising edge.
- `uart_reset`  input  1  reset; synchronous, active-high.
- `uart_d_in`  input  1  serial line, asynchronous to `uart_clock`.
- `uart_d_out`  output  8  last correctly framed byte; holds until the next good frame.
- `uart_rx_valid`  output  1  one-cycle pulse: `uart_d_out` was updated this cycle.
- `uart_frame_error`  output  1  one-cycle pulse: stop bit sampled low.
- `uart_rx_busy`  output  1  high in every state except Idle.

## Operation
- **Input synchronizer.** `uart_d_in` passes through a 2-flop synchronizer; reset value of both flops is 1. All logic uses the synchronized value `rx_s`.
- **Registers.**
  - 24-bit `clk_count`.
  - 3-bit `bit_idx`.
  - 8-bit `shift_reg`; each received bit is shifted in at bit 7 and the register shifts right, so LSB-first arrives correctly.
- **FSM states.** Idle, Start, Data, Stop, Wait_High.
- **Idle**
  - `clk_count` = 0, `bit_idx` = 0.
  - `rx_s` == 0 → Start.
- **Start**
  - `clk_count` increments each cycle.
  - At `clk_count` == HALF, sample `rx_s` and clear `clk_count`.
  - Sample 1 → false start (glitch): return to Idle, no strobe.
  - Sample 0 → Data.
- **Data**
  - `clk_count` increments.
  - At `clk_count` == BIT_CYCLES-1: sample `rx_s` into `shift_reg`, clear `clk_count`, increment `bit_idx`.
  - After the sample with `bit_idx` == 7 → Stop; `bit_idx` wraps to 0.
- **Stop**
  - At `clk_count` == BIT_CYCLES-1, sample `rx_s` and clear `clk_count`.
  - Sample 1 → next cycle `uart_d_out` <= `shift_reg`, `uart_rx_valid` = 1 for one cycle; go to Idle.
  - Sample 0 → next cycle `uart_frame_error` = 1 for one cycle; `uart_d_out` unchanged; go to Wait_High.
- **Wait_High**
  - Stays until `rx_s` == 1, then → Idle.
  - This prevents a break (line held low) from being decoded as repeated frames.
- **Strobe exclusivity.** `uart_rx_valid` and `uart_frame_error` are never high in the same cycle.
- **Back-to-back frames.** A start bit immediately following a good stop bit is accepted: Idle detects `rx_s` low on the first cycle it is observed.
- **Reset.** `uart_reset` high on any edge, including mid-frame: state → Idle and all counters cleared. No strobe is issued for the aborted frame.
- **Outputs held in reset.** `uart_d_out` = 8'h00, `uart_rx_valid` = 0, `uart_frame_error` = 0, `uart_rx_busy` = 0.

## Timing
- **Reference point.** t0 is the first cycle in Idle with `rx_s` == 0, which is 2 cycles after the falling edge appears at `uart_d_in`.
- **Sample points.**
  - Start bit sample at t0+1+HALF.
  - Data bit k (k = 0..7) sampled at t0+1+HALF+(k+1)·BIT_CYCLES.
  - Stop bit sampled at t0+1+HALF+9·BIT_CYCLES.
- **Strobe latency.** `uart_rx_valid` or `uart_frame_error` is high in cycle t0+2+HALF+9·BIT_CYCLES; with defaults that is t0+125.
- **Idle return.** The FSM is back in Idle in that same strobe cycle, able to detect the next start bit.
- **Busy window.** `uart_rx_busy` rises in cycle t0+1 and falls in the strobe cycle, unless the FSM went to Wait_High.
- **No backpressure.** The consumer must capture `uart_d_out` within one frame time, 10·BIT_CYCLES cycles.

## Test plan
- **Single byte.** Reset, then drive 0xA5 at 13 cycles/bit → `uart_rx_valid` pulses once, exactly 127 cycles after the start-bit edge at the pin; `uart_d_out` = 0xA5; `uart_frame_error` stays 0.
- **Back-to-back bytes.** Stream 0x00, 0xFF, 0x55 with no idle gap → three valid pulses 130 cycles apart, data in order.
- **Glitch rejection.** Drive a 3-cycle low glitch on an idle line → no strobe; `uart_rx_busy` high for less than 10 cycles, then returns to Idle.
- **Framing error.** Send 0x3C with stop bit 0, then hold the line low for 40 cycles, then high, then send 0x81 → one `uart_frame_error` pulse; `uart_d_out` stays at its previous value; then one valid pulse with 0x81.
- **Reset mid-frame.** Pulse `uart_reset` during data bit 4 of 0x96 → no strobe; `uart_d_out` = 0x00; a following 0x42 is received correctly.
- **Loopback.** Connect `uart_tx` (same parameters) to `uart_rx` and send 256 bytes 0x00..0xFF → all 256 received in order, zero frame errors.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, idle-high line.
// Recovers bytes from a single asynchronous wire. Each good byte appears on
// uart_d_out with a one-cycle uart_rx_valid strobe. A low stop bit gives a
// one-cycle uart_frame_error strobe instead.
module uart_rx #(
  parameter logic [23:0] baud_rate  = 24'd4000000,
  parameter logic [27:0] clock_freq = 28'd50000000
) (
  input  logic       uart_clock,
  input  logic       uart_reset,
  input  logic       uart_d_in,
  output logic [7:0] uart_d_out,
  output logic       uart_rx_valid,
  output logic       uart_frame_error,
  output logic       uart_rx_busy
);

  // Cycles per bit matches the transmitter's hold time; must be at least 4.
  localparam int unsigned BIT_CYCLES = int'(clock_freq) / int'(baud_rate) + 1;
  localparam int unsigned HALF       = BIT_CYCLES / 2;
  localparam logic [23:0] HALF_CNT   = 24'(HALF);
  localparam logic [23:0] LAST_CNT   = 24'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  logic        sync1_q;
  logic        rx_s;
  state_e      state_q,     state_d;
  logic [23:0] clk_count_q, clk_count_d;
  logic [2:0]  bit_idx_q,   bit_idx_d;
  logic [7:0]  shift_reg_q, shift_reg_d;
  logic [7:0]  d_out_q,     d_out_d;
  logic        valid_q,     valid_d;
  logic        ferr_q,      ferr_d;
  logic        busy_q,      busy_d;

  // Next-state and next-output logic for the receive FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    clk_count_d = clk_count_q;
    bit_idx_d   = bit_idx_q;
    shift_reg_d = shift_reg_q;
    d_out_d     = d_out_q;
    valid_d     = 1'b0;
    ferr_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        clk_count_d = '0;
        bit_idx_d   = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit.
        if (clk_count_q == HALF_CNT) begin
          clk_count_d = '0;
          state_d     = rx_s ? IDLE : DATA;
        end else begin
          clk_count_d = clk_count_q + 24'd1;
        end
      end
      DATA: begin
        if (clk_count_q == LAST_CNT) begin
          clk_count_d = '0;
          shift_reg_d = {rx_s, shift_reg_q[7:1]};
          bit_idx_d   = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          clk_count_d = clk_count_q + 24'd1;
        end
      end
      STOP: begin
        if (clk_count_q == LAST_CNT) begin
          clk_count_d = '0;
          if (rx_s) begin
            d_out_d = shift_reg_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          clk_count_d = clk_count_q + 24'd1;
        end
      end
      WAIT_HIGH: begin
        // A held-low line (break) must not be decoded as repeated frames.
        clk_count_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Synchronizer, FSM state and registered outputs; synchronous reset.
  always_ff @(posedge uart_clock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (uart_reset) begin
      sync1_q     <= 1'b1;
      rx_s        <= 1'b1;
      state_q     <= IDLE;
      clk_count_q <= '0;
      bit_idx_q   <= '0;
      shift_reg_q <= '0;
      d_out_q     <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= uart_d_in;
      rx_s        <= sync1_q;
      state_q     <= state_d;
      clk_count_q <= clk_count_d;
      bit_idx_q   <= bit_idx_d;
      shift_reg_q <= shift_reg_d;
      d_out_q     <= d_out_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      busy_q      <= busy_d;
    end
  end

  assign uart_d_out       = d_out_q;
  assign uart_rx_valid    = valid_q;
  assign uart_frame_error = ferr_q;
  assign uart_rx_busy     = busy_q;

endmodule
